// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised multi-stage pipeline register with per-stage
// valid bits, global stall (ENABLE), synchronous flush (FLUSH), an
// asynchronous active-high reset and a live occupancy count.
//
// Optional build macro: PIPE_COLLAPSE_EN
//   When defined, a stalled pipeline (ENABLE=0) squeezes bubbles toward the
//   output while the last stage holds. Item order is preserved. When it is
//   undefined, ENABLE=0 freezes every stage. The port list is the same in
//   both builds.
module pipe_reg_chain #(
    parameter int                 WIDTH       = 16,
    parameter int                 DEPTH       = 3,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    localparam int                OCC_W       = $clog2(DEPTH + 1)
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               FLUSH,
    input  logic [WIDTH-1:0]   D,
    input  logic               D_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   Q,
    output logic               Q_VALID,
    output logic [OCC_W-1:0]   OCCUPANCY
);

    // Per-stage storage. Stage 0 is the input end, stage DEPTH-1 drives Q.
    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;

    // load[i]   : stage i takes the item offered from upstream (D for stage 0).
    // vacate[i] : stage i hands its item forward and nothing replaces it.
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] vacate;

`ifdef PIPE_COLLAPSE_EN
    // move_fwd[i]: stage i pushes its contents into stage i+1 during a stall.
    // The last stage never moves while stalled; an upstream stage may move
    // when the stage ahead is empty or is itself moving on this edge.
    logic [DEPTH-1:0] move_fwd;

    // Resolve the stall-time move chain from the output end backwards.
    always_comb begin
        move_fwd = '0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            move_fwd[i] = ~valid_reg[i+1] | move_fwd[i+1];
        end
    end

    // Derive per-stage load/vacate controls for the collapsing build.
    always_comb begin
        load   = '0;
        vacate = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                load[i] = ENABLE | ~valid_reg[0] | move_fwd[0];
            end else begin
                load[i] = ENABLE | move_fwd[i-1];
            end
            vacate[i] = ~ENABLE & move_fwd[i] & ~load[i];
        end
    end
`else
    // Without collapse the whole chain either shifts together or holds.
    always_comb begin
        load   = {DEPTH{ENABLE}};
        vacate = '0;
    end
`endif

    // Stage 0 accepts D exactly when it loads and no flush is in progress.
    always_comb begin
        IN_READY = load[0] & ~FLUSH;
    end

    // One register stage per generate iteration; reset and flush clear it,
    // otherwise it loads from upstream, empties, or holds.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] src_data;
            logic             src_valid;

            if (gi == 0) begin : g_src_in
                assign src_data  = D;
                assign src_valid = D_VALID;
            end else begin : g_src_prev
                assign src_data  = data_reg[gi-1];
                assign src_valid = valid_reg[gi-1];
            end

            // Stage register with asynchronous reset and synchronous flush.
            always_ff @(posedge CLOCK or posedge RESET) begin
                if (RESET) begin
                    data_reg[gi]  <= RESET_VALUE;
                    valid_reg[gi] <= 1'b0;
                end else if (FLUSH) begin
                    data_reg[gi]  <= RESET_VALUE;
                    valid_reg[gi] <= 1'b0;
                end else if (load[gi]) begin
                    data_reg[gi]  <= src_data;
                    valid_reg[gi] <= src_valid;
                end else if (vacate[gi]) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Outputs come straight from the last stage's flops.
    assign Q       = data_reg[DEPTH-1];
    assign Q_VALID = valid_reg[DEPTH-1];

    // Popcount of the valid bits; bounded by DEPTH by construction.
    always_comb begin
        OCCUPANCY = '0;
        for (int i = 0; i < DEPTH; i++) begin
            OCCUPANCY = OCCUPANCY + OCC_W'(valid_reg[i]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=16, DEPTH=3).
// Expected values are hand-derived constants; the collapse scenario picks
// its expectations according to whether PIPE_COLLAPSE_EN is defined.
module tb_pipe_reg_chain;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              CLOCK;
    logic              RESET;
    logic              ENABLE;
    logic              FLUSH;
    logic [WIDTH-1:0]  D;
    logic              D_VALID;
    logic              IN_READY;
    logic [WIDTH-1:0]  Q;
    logic              Q_VALID;
    logic [OCC_W-1:0]  OCCUPANCY;

    int check_count;
    int pass_count;

    pipe_reg_chain #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (16'h0000)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .FLUSH     (FLUSH),
        .D         (D),
        .D_VALID   (D_VALID),
        .IN_READY  (IN_READY),
        .Q         (Q),
        .Q_VALID   (Q_VALID),
        .OCCUPANCY (OCCUPANCY)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
            $display("check %-18s got=0x%0h exp=0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-18s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        RESET   = 1'b1;
        ENABLE  = 1'b0;
        FLUSH   = 1'b0;
        D       = '0;
        D_VALID = 1'b0;

        // Reset takes effect with no clock edge.
        #1;
        chk("rst_q",      32'(Q),         32'h0);
        chk("rst_qvalid", 32'(Q_VALID),   32'h0);
        chk("rst_occ",    32'(OCCUPANCY), 32'h0);

        tick(); tick();
        RESET = 1'b0;

        // Latency: one item, DEPTH edges to reach Q.
        ENABLE = 1'b1; D = 16'h0008; D_VALID = 1'b1;
        #1;
        chk("lat_in_ready", 32'(IN_READY), 32'h1);
        tick();
        D = 16'h0000; D_VALID = 1'b0;
        chk("lat_e1_qv", 32'(Q_VALID), 32'h0);
        tick();
        chk("lat_e2_qv", 32'(Q_VALID), 32'h0);
        tick();
        chk("lat_e3_qv", 32'(Q_VALID), 32'h1);
        chk("lat_e3_q",  32'(Q),       32'h0008);
        tick();
        chk("lat_e4_qv", 32'(Q_VALID), 32'h0);

        // Stall: stream 3,2,1 so 0x0003 reaches Q first, then freeze.
        D = 16'h0003; D_VALID = 1'b1; tick();
        D = 16'h0002; tick();
        D = 16'h0001; tick();
        ENABLE = 1'b0; D = 16'h0055; D_VALID = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_q",     32'(Q),         32'h0003);
        chk("stall_qv",    32'(Q_VALID),   32'h1);
        chk("stall_occ",   32'(OCCUPANCY), 32'h3);
        chk("stall_ready", 32'(IN_READY),  32'h0);
        ENABLE = 1'b1; D_VALID = 1'b0; D = 16'h0000;
        tick();
        chk("resume1_q",   32'(Q),         32'h0002);
        chk("resume1_qv",  32'(Q_VALID),   32'h1);
        chk("resume1_occ", 32'(OCCUPANCY), 32'h2);
        tick();
        chk("resume2_q",   32'(Q),         32'h0001);
        chk("resume2_qv",  32'(Q_VALID),   32'h1);
        tick();
        chk("resume3_qv",  32'(Q_VALID),   32'h0);
        chk("resume3_occ", 32'(OCCUPANCY), 32'h0);

        // Flush beats enable; the item offered with the flush is dropped.
        D_VALID = 1'b1;
        D = 16'h0010; tick();
        D = 16'h0020; tick();
        D = 16'h0030; tick();
        chk("full_occ", 32'(OCCUPANCY), 32'h3);
        FLUSH = 1'b1; D = 16'hBEEF;
        #1;
        chk("flush_ready", 32'(IN_READY), 32'h0);
        tick();
        FLUSH = 1'b0; D_VALID = 1'b0; D = 16'h0000;
        chk("flush_occ", 32'(OCCUPANCY), 32'h0);
        chk("flush_qv",  32'(Q_VALID),   32'h0);
        chk("flush_q",   32'(Q),         32'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_after_qv", 32'(Q_VALID), 32'h0);
        end

        // Asynchronous reset between edges while two items are in flight.
        D_VALID = 1'b1;
        D = 16'h0041; tick();
        D = 16'h0042; tick();
        D_VALID = 1'b0; D = 16'h0000;
        chk("pre_rst_occ", 32'(OCCUPANCY), 32'h2);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_occ", 32'(OCCUPANCY), 32'h0);
        chk("async_rst_q",   32'(Q),         32'h0000);
        tick();
        #3;
        RESET = 1'b0;
        D = 16'h00AA; D_VALID = 1'b1;
        tick();
        D_VALID = 1'b0; D = 16'h0000;
        chk("post_rst_e1_qv", 32'(Q_VALID), 32'h0);
        tick();
        chk("post_rst_e2_qv", 32'(Q_VALID), 32'h0);
        tick();
        chk("post_rst_e3_qv", 32'(Q_VALID), 32'h1);
        chk("post_rst_e3_q",  32'(Q),       32'h00AA);
        tick(); tick();

        // Build valid, bubble, valid: Q=0x0011, stage0=0x0022.
        D = 16'h0011; D_VALID = 1'b1; tick();
        D_VALID = 1'b0; D = 16'h0000; tick();
        D = 16'h0022; D_VALID = 1'b1; tick();
        chk("gap_q",   32'(Q),         32'h0011);
        chk("gap_occ", 32'(OCCUPANCY), 32'h2);
        ENABLE = 1'b0; D = 16'h0033; D_VALID = 1'b1;
        #1;
`ifdef PIPE_COLLAPSE_EN
        chk("gap_ready", 32'(IN_READY), 32'h1);
`else
        chk("gap_ready", 32'(IN_READY), 32'h0);
`endif
        tick();
        chk("gap_stall_q", 32'(Q), 32'h0011);
`ifdef PIPE_COLLAPSE_EN
        chk("gap_stall_occ",   32'(OCCUPANCY), 32'h3);
        chk("gap_stall_ready", 32'(IN_READY),  32'h0);
`else
        chk("gap_stall_occ",   32'(OCCUPANCY), 32'h2);
        chk("gap_stall_ready", 32'(IN_READY),  32'h0);
`endif
        ENABLE = 1'b1; D_VALID = 1'b0; D = 16'h0000;
        tick();
`ifdef PIPE_COLLAPSE_EN
        chk("drain1_q",  32'(Q),       32'h0022);
        chk("drain1_qv", 32'(Q_VALID), 32'h1);
        tick();
        chk("drain2_q",  32'(Q),       32'h0033);
        chk("drain2_qv", 32'(Q_VALID), 32'h1);
`else
        chk("drain1_qv", 32'(Q_VALID), 32'h0);
        tick();
        chk("drain2_q",  32'(Q),       32'h0022);
        chk("drain2_qv", 32'(Q_VALID), 32'h1);
`endif
        tick(); tick();
        chk("drain_end_occ", 32'(OCCUPANCY), 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
